iob_ibex_bus_arbiter: RTL

- Shares one AXI4 master port between the Ibex instruction-fetch and data (LSU) request ports. Both request ports use the Ibex req/gnt/rvalid protocol with 30-bit word addresses.
- Sits between the Ibex core and the system interconnect as a single-master alternative to separate ibus/dbus masters.
- Round-robin arbitration; one outstanding transaction at a time.

---
 rtl/iob_ibex_bus_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/iob_ibex_bus_arbiter.sv
// iob_ibex_bus_arbiter
// Shares a single AXI4 master port between the Ibex instruction-fetch port and
// the Ibex data (LSU) port. Both core-side ports speak the Ibex req/gnt/rvalid
// protocol with word addresses. One transaction is in flight at a time.
// Every burst is a single 32-bit beat.
//
// Optional build macro:
//   IOB_IBEX_ARB_DATA_PRIO_EN - data port wins on simultaneous requests (fixed
//                               priority). Undefined: round-robin between ports.
//
// Ports:
//   clk_i, rst_ni, cke_i       clock, async active-low reset, clock enable
//   instr_*                    fetch port (read-only): req/addr in; gnt/rvalid/rdata/err out
//   data_*                     LSU port: req/we/be/addr/wdata in; gnt/rvalid/rdata/err out
//   axi_ar*/axi_r*             AXI4 read address / read data channels
//   axi_aw*/axi_w*/axi_b*      AXI4 write address / write data / write response channels
module iob_ibex_bus_arbiter #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cke_i,
  // instruction fetch port
  input  logic                  instr_req_i,
  input  logic [AXI_ADDR_W-3:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_err_o,
  // data (LSU) port
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [AXI_ADDR_W-3:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic                  data_err_o,
  output logic [31:0]           data_rdata_o,
  // AXI read address channel
  output logic                  axi_arvalid_o,
  output logic [AXI_ADDR_W-3:0] axi_araddr_o,
  output logic [2:0]            axi_arprot_o,
  output logic [AXI_ID_W-1:0]   axi_arid_o,
  output logic [AXI_LEN_W-1:0]  axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  input  logic                  axi_arready_i,
  // AXI read data channel
  input  logic                  axi_rvalid_i,
  input  logic [AXI_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  output logic                  axi_rready_o,
  // AXI write address channel
  output logic                  axi_awvalid_o,
  output logic [AXI_ADDR_W-3:0] axi_awaddr_o,
  output logic [2:0]            axi_awprot_o,
  output logic [AXI_ID_W-1:0]   axi_awid_o,
  output logic [AXI_LEN_W-1:0]  axi_awlen_o,
  output logic [2:0]            axi_awsize_o,
  output logic [1:0]            axi_awburst_o,
  input  logic                  axi_awready_i,
  // AXI write data channel
  output logic                  axi_wvalid_o,
  output logic [AXI_DATA_W-1:0] axi_wdata_o,
  output logic [3:0]            axi_wstrb_o,
  output logic                  axi_wlast_o,
  input  logic                  axi_wready_i,
  // AXI write response channel
  input  logic                  axi_bvalid_i,
  input  logic [1:0]            axi_bresp_i,
  output logic                  axi_bready_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR   = 3'd1;
  localparam logic [2:0] R    = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] B    = 3'd4;

  logic [2:0]            state_q;
  logic [AXI_ADDR_W-3:0] addr_q;
  logic [AXI_DATA_W-1:0] wdata_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [3:0]            be_q;
  logic                  owner_q;   // 1 = data port owns the transaction
  logic                  err_q;
  logic                  rvalid_q;  // one-cycle response pulse
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  sel_data;
  logic                  grant_any;

  // rlast carries no information for single-beat bursts.
  logic unused_rlast;
  assign unused_rlast = axi_rlast_i;

`ifdef IOB_IBEX_ARB_DATA_PRIO_EN
  assign sel_data = data_req_i;
`else
  // Set when the data port should win the next tie (instr was granted last).
  logic prio_data_q;
  assign sel_data = data_req_i & (~instr_req_i | prio_data_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_data_q <= 1'b0;
    end else if (cke_i && grant_any) begin
      prio_data_q <= instr_gnt_o;
    end
  end
`endif

  // Grant is combinational from IDLE so a request can be accepted in the same
  // cycle the previous response pulse is presented.
  assign instr_gnt_o = (state_q == IDLE) & cke_i & instr_req_i & ~sel_data;
  assign data_gnt_o  = (state_q == IDLE) & cke_i & sel_data;
  assign grant_any   = instr_gnt_o | data_gnt_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      be_q      <= '0;
      owner_q   <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (cke_i) begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            addr_q    <= data_gnt_o ? data_addr_i : instr_addr_i;
            wdata_q   <= data_wdata_i;
            be_q      <= data_be_i;
            owner_q   <= data_gnt_o;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            // The fetch port is read-only; only the LSU can start a write.
            state_q   <= (data_gnt_o && data_we_i) ? WR : AR;
          end
        end
        AR: if (axi_arready_i) state_q <= R;
        R: begin
          if (axi_rvalid_i) begin
            rdata_q  <= axi_rdata_i;
            err_q    <= (axi_rresp_i != 2'b00);
            rvalid_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        WR: begin
          // AW and W complete independently, in either order or together.
          if (axi_awready_i) aw_done_q <= 1'b1;
          if (axi_wready_i)  w_done_q  <= 1'b1;
          if ((aw_done_q || axi_awready_i) && (w_done_q || axi_wready_i)) state_q <= B;
        end
        B: begin
          if (axi_bvalid_i) begin
            rdata_q  <= '0;
            err_q    <= (axi_bresp_i != 2'b00);
            rvalid_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Core-side responses
  assign instr_rvalid_o = rvalid_q & ~owner_q;
  assign data_rvalid_o  = rvalid_q & owner_q;
  assign instr_err_o    = instr_rvalid_o & err_q;
  assign data_err_o     = data_rvalid_o & err_q;
  assign instr_rdata_o  = rdata_q;
  assign data_rdata_o   = rdata_q;

  // Read channels
  assign axi_arvalid_o = (state_q == AR);
  assign axi_araddr_o  = addr_q;
  assign axi_arprot_o  = owner_q ? 3'b000 : 3'b100;
  assign axi_arid_o    = '0;
  assign axi_arlen_o   = '0;
  assign axi_arsize_o  = 3'b010;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = (state_q == R);

  // Write channels
  assign axi_awvalid_o = (state_q == WR) & ~aw_done_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awprot_o  = 3'b000;
  assign axi_awid_o    = '0;
  assign axi_awlen_o   = '0;
  assign axi_awsize_o  = 3'b010;
  assign axi_awburst_o = 2'b01;
  assign axi_wvalid_o  = (state_q == WR) & ~w_done_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = be_q;
  assign axi_wlast_o   = axi_wvalid_o;
  assign axi_bready_o  = (state_q == B);

endmodule
